am_error_monitor: RTL and testbench

Streaming error-metric collector that sits directly downstream of the 8x8 approximate recursive multipliers. For each accepted sample it takes the operands and the approximate product, computes the exact product internally, and accumulates error statistics over a fixed run of 2^SAMPLES_LOG2 samples. Those statistics are the sum of error distances, mean error distance, maximum error distance and count of erroneous products. It is used in characterisation benches and on-chip to qualify approximate multiplier variants.

---
 rtl/am_error_monitor_pkg.sv | 21 ++
 rtl/am_error_monitor_if.sv | 13 +
 rtl/am_error_monitor_err_stage.sv | 67 ++++++
 rtl/am_error_monitor.sv | 119 +++++++++++
 tb/tb_am_error_monitor.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/am_error_monitor_pkg.sv
// Shared types and width helpers for the approximate-multiplier error monitor
// and the multiplier characterisation benches.
package am_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} am_mon_state_t;

  localparam int unsigned AM_WIDTH = 8;

  function automatic int unsigned am_prod_w(int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned am_sum_w(int unsigned w, int unsigned s);
    return 2 * w + s;
  endfunction

  function automatic int unsigned am_cnt_w(int unsigned s);
    return s + 1;
  endfunction

endpackage

// File: rtl/am_error_monitor_if.sv
// Sample stream into the error monitor: operands, approximate product, handshake.
interface am_error_monitor_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [2*WIDTH-1:0]   in_y;

  modport master (output in_valid, output in_a, output in_b, output in_y, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, input in_y, output in_ready);
endinterface

// File: rtl/am_error_monitor_err_stage.sv
// Two-stage error-distance pipe: S1 captures a/b/y, S2 holds exact product and
// |a*b - y|. Latency 2 from in_valid to out_valid.
module am_err_stage
  import am_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  input  logic [am_prod_w(WIDTH)-1:0]   y,
  output logic                          out_valid,
  output logic [am_prod_w(WIDTH)-1:0]   out_ed
);

  localparam int unsigned PW = am_prod_w(WIDTH);

  logic            s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [PW-1:0]   s1_y_q, s1_y_d;
  logic            s2_valid_q, s2_valid_d;
  logic [PW-1:0]   s2_exact_q, s2_exact_d;
  logic [PW-1:0]   s2_ed_q, s2_ed_d;
  logic [PW:0]     diff;

  always_comb begin
    s1_valid_d = in_valid;
    s1_a_d     = in_valid ? a : s1_a_q;
    s1_b_d     = in_valid ? b : s1_b_q;
    s1_y_d     = in_valid ? y : s1_y_q;

    s2_valid_d = s1_valid_q;
    s2_exact_d = PW'(s1_a_q) * PW'(s1_b_q);
    // Extra sign bit so y > exact yields a negative difference, not a wrap.
    diff       = {1'b0, s2_exact_d} - {1'b0, s1_y_q};
    s2_ed_d    = diff[PW] ? (~diff[PW-1:0] + PW'(1)) : diff[PW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_y_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_exact_q <= '0;
      s2_ed_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_y_q     <= s1_y_d;
      s2_valid_q <= s2_valid_d;
      s2_exact_q <= s2_exact_d;
      s2_ed_q    <= s2_ed_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_ed    = s2_ed_q;

  logic unused_exact;
  assign unused_exact = ^s2_exact_q;

endmodule

// File: rtl/am_error_monitor.sv
// Streaming error-metric collector for approximate multipliers: accumulates
// sum, mean, max of |a*b - y| and error count over 2^SAMPLES_LOG2 samples.
module am_error_monitor
  import am_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned SAMPLES_LOG2 = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  am_error_monitor_if.slave                        in_if,
  output logic                                     busy,
  output logic                                     done,
  output logic [am_sum_w(WIDTH, SAMPLES_LOG2)-1:0] sum_ed,
  output logic [am_prod_w(WIDTH)-1:0]              mean_ed,
  output logic [am_prod_w(WIDTH)-1:0]              max_ed,
  output logic [am_cnt_w(SAMPLES_LOG2)-1:0]        err_count
);

  localparam int unsigned PW    = am_prod_w(WIDTH);
  localparam int unsigned SUM_W = am_sum_w(WIDTH, SAMPLES_LOG2);
  localparam int unsigned CNT_W = am_cnt_w(SAMPLES_LOG2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << SAMPLES_LOG2) - 1);

  am_mon_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain_q, drain_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [PW-1:0]    max_q, max_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic             accept;
  logic             st_valid;
  logic [PW-1:0]    st_ed;

  assign accept = (state_q == RUN) && in_if.in_valid;

  am_err_stage #(.WIDTH(WIDTH)) u_err_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .a         (in_if.in_a),
    .b         (in_if.in_b),
    .y         (in_if.in_y),
    .out_valid (st_valid),
    .out_ed    (st_ed)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    sum_d   = sum_q;
    max_d   = max_q;
    err_d   = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          sum_d   = '0;
          max_d   = '0;
          err_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      // The pipe latency is fixed at 2, so DRAIN lasts exactly two cycles and
      // the transition to DONE lands on the final accumulation edge.
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (st_valid && (state_q == RUN || state_q == DRAIN)) begin
      sum_d = sum_q + SUM_W'(st_ed);
      if (st_ed > max_q) max_d = st_ed;
      if (st_ed != '0)   err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      sum_q   <= '0;
      max_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      err_q   <= err_d;
    end
  end

  assign in_if.in_ready = (state_q == RUN);
  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign sum_ed         = sum_q;
  assign mean_ed        = sum_q[SUM_W-1:SAMPLES_LOG2];
  assign max_ed         = max_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_am_error_monitor.sv
// Directed bench for am_error_monitor: N=4 instance for functional/latency
// vectors, N=16 instance for the full-scale accumulation case.
module tb_am_error_monitor;

  logic clk = 1'b0;
  logic rst_n;
  logic start2, start4;

  always #5 clk = ~clk;

  am_error_monitor_if #(.WIDTH(8)) bus2 ();
  am_error_monitor_if #(.WIDTH(8)) bus4 ();

  logic        busy2, done2, busy4, done4;
  logic [17:0] sum2;
  logic [15:0] mean2, max2;
  logic [2:0]  err2;
  logic [19:0] sum4;
  logic [15:0] mean4, max4;
  logic [4:0]  err4;

  am_error_monitor #(.WIDTH(8), .SAMPLES_LOG2(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_if(bus2),
    .busy(busy2), .done(done2), .sum_ed(sum2), .mean_ed(mean2),
    .max_ed(max2), .err_count(err2)
  );

  am_error_monitor #(.WIDTH(8), .SAMPLES_LOG2(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .in_if(bus4),
    .busy(busy4), .done(done4), .sum_ed(sum4), .mean_ed(mean4),
    .max_ed(max4), .err_count(err4)
  );

  typedef struct {
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic [3:0][15:0] y;
    logic [3:0][1:0]  gap;
    logic [17:0]      sum;
    logic [15:0]      mean;
    logic [15:0]      max;
    logic [2:0]       err;
  } vec_t;

  vec_t vecs [4];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b, input logic [15:0] y,
                       input logic with_start);
    bus2.in_valid = 1'b1;
    bus2.in_a = a; bus2.in_b = b; bus2.in_y = y;
    start2 = with_start;
    tick();
    bus2.in_valid = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic gap2(input int n);
    for (int i = 0; i < n; i++) begin
      bus2.in_valid = 1'b0;
      bus2.in_a = 8'($urandom); bus2.in_b = 8'($urandom); bus2.in_y = 16'($urandom);
      tick();
    end
  endtask

  task automatic chk_stats2(input string tag, input int idx);
    chk({tag, " sum_ed"},    sum2,  vecs[idx].sum);
    chk({tag, " mean_ed"},   mean2, vecs[idx].mean);
    chk({tag, " max_ed"},    max2,  vecs[idx].max);
    chk({tag, " err_count"}, err2,  vecs[idx].err);
  endtask

  task automatic run_vec(input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk({tag, " busy_in_run"},  busy2,         1);
    chk({tag, " ready_in_run"}, bus2.in_ready, 1);
    chk({tag, " done_cleared"}, done2,         0);
    for (int i = 0; i < 4; i++) begin
      gap2(int'(vecs[idx].gap[i]));
      send2(vecs[idx].a[i], vecs[idx].b[i], vecs[idx].y[i], 1'b0);
    end
    chk({tag, " ready_after_last"}, bus2.in_ready, 0);
    chk({tag, " done_at_k"},        done2,         0);
    tick();
    chk({tag, " done_at_k1"},       done2,         0);
    tick();
    chk({tag, " done_at_k2"},       done2,         1);
    chk({tag, " busy_at_done"},     busy2,         0);
    chk_stats2(tag, idx);
  endtask

  initial begin
    // exact products
    vecs[0].a = {8'd12, 8'd0, 8'd255, 8'd3};
    vecs[0].b = {8'd12, 8'd9, 8'd255, 8'd5};
    vecs[0].y = {16'd144, 16'd0, 16'd65025, 16'd15};
    vecs[0].gap = '0;
    vecs[0].sum = 18'd0; vecs[0].mean = 16'd0; vecs[0].max = 16'd0; vecs[0].err = 3'd0;
    // mixed errors, one with y > exact
    vecs[1].a = {8'd255, 8'd200, 8'd2, 8'd15};
    vecs[1].b = {8'd255, 8'd100, 8'd3, 8'd15};
    vecs[1].y = {16'd64769, 16'd20000, 16'd10, 16'd209};
    vecs[1].gap = '0;
    vecs[1].sum = 18'd276; vecs[1].mean = 16'd69; vecs[1].max = 16'd256; vecs[1].err = 3'd3;
    // same samples with valid bubbles
    vecs[2] = vecs[1];
    vecs[2].gap = {2'd1, 2'd2, 2'd3, 2'd1};
    // large y > exact, truncated mean: eds 65534, 1, 0, 300
    vecs[3].a = {8'd100, 8'd16, 8'd0, 8'd1};
    vecs[3].b = {8'd3, 8'd16, 8'd0, 8'd1};
    vecs[3].y = {16'd0, 16'd256, 16'd1, 16'd65535};
    vecs[3].gap = {2'd1, 2'd0, 2'd2, 2'd0};
    vecs[3].sum = 18'd65835; vecs[3].mean = 16'd16458; vecs[3].max = 16'd65534; vecs[3].err = 3'd3;

    rst_n = 1'b0;
    start2 = 1'b0; start4 = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_y = '0;
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_y = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    chk("rst in_ready", bus2.in_ready, 0);
    chk("rst busy",     busy2, 0);
    chk("rst done",     done2, 0);
    chk("rst sum_ed",   sum2,  0);
    chk("rst mean_ed",  mean2, 0);
    chk("rst max_ed",   max2,  0);
    chk("rst err",      err2,  0);
    chk("rst done4",    done4, 0);

    for (int v = 0; v < 4; v++) run_vec(v);

    // done and results held while idle in DONE
    tick(); tick(); tick();
    chk("hold done",   done2, 1);
    chk("hold sum_ed", sum2,  vecs[3].sum);

    // start pulses during RUN and DRAIN must be ignored
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    send2(vecs[1].a[0], vecs[1].b[0], vecs[1].y[0], 1'b0);
    send2(vecs[1].a[1], vecs[1].b[1], vecs[1].y[1], 1'b1);
    send2(vecs[1].a[2], vecs[1].b[2], vecs[1].y[2], 1'b0);
    send2(vecs[1].a[3], vecs[1].b[3], vecs[1].y[3], 1'b0);
    chk("busy_start drain busy", busy2, 1);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("busy_start done_k1", done2, 0);
    tick();
    chk("busy_start done_k2", done2, 1);
    chk_stats2("busy_start", 1);

    // reset mid-run discards partial results
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    send2(8'd15, 8'd15, 16'd209, 1'b0);
    send2(8'd2, 8'd3, 16'd10, 1'b0);
    tick();
    chk("midrun partial sum", sum2, 16);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort in_ready", bus2.in_ready, 0);
    chk("abort busy",     busy2, 0);
    chk("abort done",     done2, 0);
    chk("abort sum_ed",   sum2,  0);
    chk("abort mean_ed",  mean2, 0);
    chk("abort max_ed",   max2,  0);
    chk("abort err",      err2,  0);
    tick();
    chk("abort stays idle", busy2, 0);
    run_vec(3);

    // N=16 full-scale errors: 16 * 65025 must not wrap
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_a = 8'd255; bus4.in_b = 8'd255; bus4.in_y = 16'd0;
      tick();
    end
    bus4.in_valid = 1'b0;
    chk("sat ready_after_last", bus4.in_ready, 0);
    tick();
    chk("sat done_k1", done4, 0);
    tick();
    chk("sat done",      done4, 1);
    chk("sat sum_ed",    sum4,  1040400);
    chk("sat mean_ed",   mean4, 65025);
    chk("sat max_ed",    max4,  65025);
    chk("sat err_count", err4,  16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
